// File: rtl/dma_engine_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine:
// controller state encoding, bus word size and the default data/address width.
package dma_engine_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/dma_engine.sv
// Word-by-word memory copy engine acting as a single-outstanding bus initiator.
// Each word costs read request, read wait and write request (3 cycles minimum).
module dma_engine
   import dma_engine_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int LEN_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [XLEN-1:0]   src_addr,
   input  logic [XLEN-1:0]   dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remain,
   output logic              dma_req,
   output logic              dma_write,
   output logic [XLEN/8-1:0] dma_wstrb,
   output logic [XLEN-1:0]   dma_addr,
   output logic [XLEN-1:0]   dma_wdata,
   input  logic              dma_ready,
   input  logic              dma_rvalid,
   input  logic [XLEN-1:0]   dma_rdata
);

   localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(WORD_BYTES - 1);
   localparam logic [XLEN-1:0] STEP      = XLEN'(WORD_BYTES);

   state_t          state;
   logic [XLEN-1:0] src_ptr;
   logic [XLEN-1:0] dst_ptr;
   logic [XLEN-1:0] src_next;
   logic [XLEN-1:0] dst_next;
   logic            accept;
   logic            last_word;

   // Pointers wrap naturally modulo 2^XLEN.
   assign src_next  = src_ptr + STEP;
   assign dst_next  = dst_ptr + STEP;
   assign accept    = dma_req && dma_ready;
   assign last_word = (remain == LEN_W'(1));

   // All bus and status outputs are registered and change together with state,
   // so they are naturally held while a request waits for dma_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remain    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dma_req   <= 1'b0;
         dma_write <= 1'b0;
         dma_wstrb <= '0;
         dma_addr  <= '0;
         dma_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  src_ptr <= src_addr & ADDR_MASK;
                  dst_ptr <= dst_addr & ADDR_MASK;
                  remain  <= len;
                  if (len != '0) begin
                     state     <= ST_RD_REQ;
                     busy      <= 1'b1;
                     dma_req   <= 1'b1;
                     dma_write <= 1'b0;
                     dma_wstrb <= '0;
                     dma_addr  <= src_addr & ADDR_MASK;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end

            ST_RD_REQ: begin
               if (accept) begin
                  state   <= ST_RD_WAIT;
                  dma_req <= 1'b0;
               end
            end

            // dma_wdata doubles as the captured data register.
            ST_RD_WAIT: begin
               if (dma_rvalid) begin
                  state     <= ST_WR_REQ;
                  dma_wdata <= dma_rdata;
                  dma_req   <= 1'b1;
                  dma_write <= 1'b1;
                  dma_wstrb <= '1;
                  dma_addr  <= dst_ptr;
               end
            end

            ST_WR_REQ: begin
               if (accept) begin
                  remain    <= remain - LEN_W'(1);
                  src_ptr   <= src_next;
                  dst_ptr   <= dst_next;
                  dma_write <= 1'b0;
                  dma_wstrb <= '0;
                  if (last_word) begin
                     state   <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     dma_req <= 1'b0;
                  end else begin
                     state    <= ST_RD_REQ;
                     dma_req  <= 1'b1;
                     dma_addr <= src_next;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               dma_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a 1-cycle-latency RAM model.
module tb_dma_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy, done;
   logic [15:0] remain;
   logic        dma_req, dma_write;
   logic [3:0]  dma_wstrb;
   logic [31:0] dma_addr, dma_wdata;
   logic        dma_ready;
   logic        dma_rvalid = 1'b0;
   logic [31:0] dma_rdata = '0;

   int total = 0;
   int bad = 0;

   bit stall_en = 1'b0;
   int req_age = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [3:0]  wr_strb_q[$];
   logic [31:0] rd_addr_q[$];

   dma_engine #(.XLEN(32), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .remain(remain),
      .dma_req(dma_req), .dma_write(dma_write), .dma_wstrb(dma_wstrb),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata)
   );

   always #5 clk = ~clk;

   // Stall mode holds ready low for 3 cycles at the start of every request.
   assign dma_ready = stall_en ? (req_age == 3) : 1'b1;

   always @(posedge clk) begin
      if (dma_req && !dma_ready) req_age <= req_age + 1;
      else                       req_age <= 0;
      // RAM: source word = 0xC0DE0000 ^ address, returned one cycle after accept.
      if (dma_req && dma_ready && !dma_write) begin
         dma_rvalid <= 1'b1;
         dma_rdata  <= 32'hC0DE_0000 ^ dma_addr;
      end else begin
         dma_rvalid <= 1'b0;
         dma_rdata  <= 32'hDEAD_BEEF;
      end
      if (!rst && dma_req && dma_ready) begin
         if (dma_write) begin
            wr_addr_q.push_back(dma_addr);
            wr_data_q.push_back(dma_wdata);
            wr_strb_q.push_back(dma_wstrb);
         end else begin
            rd_addr_q.push_back(dma_addr);
         end
      end
   end

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_strb_q.delete(); rd_addr_q.delete();
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cyc, output bit seen);
      cyc = 1; seen = 1'b0;
      while (cyc <= max) begin
         if (done) begin seen = 1'b1; break; end
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (dma_req !== 1'b0)   begin bad++; $display("FAIL reset_req got=%b want=0", dma_req); end
      total++; if (dma_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", dma_write); end
      total++; if (dma_wstrb !== 4'h0) begin bad++; $display("FAIL reset_wstrb got=%h want=0", dma_wstrb); end
      total++; if (dma_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", dma_addr); end
      total++; if (dma_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", dma_wdata); end
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
      total++; if (remain !== 16'h0)   begin bad++; $display("FAIL reset_remain got=%0d want=0", remain); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc; bit seen;
      logic [31:0] exp_data [4] = '{32'hC0DE0100, 32'hC0DE0104, 32'hC0DE0108, 32'hC0DE010C};
      clear_logs();
      do_start(32'h100, 32'h200, 16'd4);
      total++; if (busy !== 1'b1)   begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      total++; if (remain !== 16'd4) begin bad++; $display("FAIL basic_remain_load got=%0d want=4", remain); end
      total++; if (dma_req !== 1'b1 || dma_write !== 1'b0 || dma_addr !== 32'h100)
         begin bad++; $display("FAIL basic_first_read got=%b/%b/%h want=1/0/00000100", dma_req, dma_write, dma_addr); end
      wait_done(40, cyc, seen);
      total++; if (!seen || cyc != 13) begin bad++; $display("FAIL basic_done_cycle got=%0d seen=%b want=13", cyc, seen); end
      total++; if (remain !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL basic_end_state remain=%0d busy=%b want=0/0", remain, busy); end
      total++; if (wr_addr_q.size() != 4) begin bad++; $display("FAIL basic_write_count got=%0d want=4", wr_addr_q.size()); end
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
         total++;
         if (wr_addr_q[i] !== 32'h200 + 32'(4 * i) || wr_data_q[i] !== exp_data[i] || wr_strb_q[i] !== 4'hF) begin
            bad++;
            $display("FAIL basic_write%0d got=%h:%h:%h want=%h:%h:f", i, wr_addr_q[i], wr_data_q[i], wr_strb_q[i],
                     32'h200 + 32'(4 * i), exp_data[i]);
         end
      end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width got=%b want=0", done); end
   endtask

   task automatic test_zero_len();
      bit saw_req = 1'b0;
      clear_logs();
      src_addr = 32'h100; dst_addr = 32'h200; len = 16'd0; start = 1'b1;
      if (dma_req) saw_req = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got done=%b busy=%b want=1/0", done, busy); end
      for (int i = 0; i < 4; i++) begin
         if (dma_req) saw_req = 1'b1;
         @(posedge clk); #1;
      end
      total++; if (saw_req || (rd_addr_q.size() + wr_addr_q.size()) != 0) begin bad++; $display("FAIL zero_no_req got=%b want=0", saw_req); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", done); end
   endtask

   task automatic test_stall();
      bit prev_hold = 1'b0;
      logic [69:0] prev_sig = '0;
      bit seen = 1'b0;
      int unstable = 0;
      clear_logs();
      stall_en = 1'b1;
      do_start(32'h300, 32'h400, 16'd2);
      for (int c = 0; c < 200; c++) begin
         if (prev_hold && {dma_req, dma_write, dma_wstrb, dma_addr, dma_wdata} !== prev_sig) unstable++;
         prev_hold = dma_req && !dma_ready;
         prev_sig  = {dma_req, dma_write, dma_wstrb, dma_addr, dma_wdata};
         if (done) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      stall_en = 1'b0;
      total++; if (!seen) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
      total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d changes want=0", unstable); end
      total++; if (rd_addr_q.size() != 2 || wr_addr_q.size() != 2)
         begin bad++; $display("FAIL stall_accepts got=%0d/%0d want=2/2", rd_addr_q.size(), wr_addr_q.size()); end
      if (wr_addr_q.size() == 2) begin
         total++;
         if (wr_addr_q[0] !== 32'h400 || wr_data_q[0] !== 32'hC0DE0300 || wr_addr_q[1] !== 32'h404 || wr_data_q[1] !== 32'hC0DE0304) begin
            bad++; $display("FAIL stall_data got=%h:%h,%h:%h want=400:c0de0300,404:c0de0304", wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_restart_ignored();
      int cyc; bit seen;
      clear_logs();
      do_start(32'h500, 32'h600, 16'd3);
      @(posedge clk); #1;
      src_addr = 32'h900; dst_addr = 32'hA00; len = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (remain !== 16'd3 || busy !== 1'b1) begin bad++; $display("FAIL restart_remain got=%0d busy=%b want=3/1", remain, busy); end
      wait_done(40, cyc, seen);
      total++; if (!seen || cyc != 8) begin bad++; $display("FAIL restart_done got=%0d seen=%b want=8", cyc, seen); end
      total++; if (wr_addr_q.size() != 3) begin bad++; $display("FAIL restart_count got=%0d want=3", wr_addr_q.size()); end
      if (wr_addr_q.size() == 3) begin
         total++;
         if (wr_addr_q[2] !== 32'h608 || wr_data_q[2] !== 32'hC0DE0508 || wr_addr_q[0] !== 32'h600) begin
            bad++; $display("FAIL restart_data got=%h:%h want=608:c0de0508", wr_addr_q[2], wr_data_q[2]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc; bit seen; bit saw_done = 1'b0; int n;
      clear_logs();
      do_start(32'h700, 32'h800, 16'd8);
      n = 0;
      while (wr_addr_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
      total++; if (wr_addr_q.size() != 2) begin bad++; $display("FAIL rstmid_reach got=%0d writes want=2", wr_addr_q.size()); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if ({dma_req, busy} !== 2'b00 || remain !== 16'd0)
         begin bad++; $display("FAIL rstmid_outputs got req=%b busy=%b remain=%0d want=0/0/0", dma_req, busy, remain); end
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         if (done || dma_req) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      total++; if (saw_done || wr_addr_q.size() != 0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", saw_done); end
      do_start(32'h104, 32'h208, 16'd1);
      wait_done(20, cyc, seen);
      total++; if (!seen || cyc != 4) begin bad++; $display("FAIL rstmid_rerun_done got=%0d seen=%b want=4", cyc, seen); end
      total++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h208 || wr_data_q[0] !== 32'hC0DE0104)
         begin bad++; $display("FAIL rstmid_rerun_write got=%0d writes want=1 at 208 data c0de0104", wr_addr_q.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap_align();
      int cyc; bit seen;
      clear_logs();
      do_start(32'hFFFF_FFFC, 32'h1000, 16'd2);
      wait_done(30, cyc, seen);
      total++; if (!seen || rd_addr_q.size() != 2) begin bad++; $display("FAIL wrap_reads got=%0d seen=%b want=2", rd_addr_q.size(), seen); end
      if (rd_addr_q.size() == 2) begin
         total++; if (rd_addr_q[1] !== 32'h0 || rd_addr_q[0] !== 32'hFFFF_FFFC)
            begin bad++; $display("FAIL wrap_addr got=%h,%h want=fffffffc,00000000", rd_addr_q[0], rd_addr_q[1]); end
      end
      if (wr_data_q.size() == 2) begin
         total++; if (wr_data_q[0] !== 32'h3F21_FFFC || wr_data_q[1] !== 32'hC0DE_0000 || wr_addr_q[1] !== 32'h1004)
            begin bad++; $display("FAIL wrap_data got=%h,%h want=3f21fffc,c0de0000", wr_data_q[0], wr_data_q[1]); end
      end
      @(posedge clk); #1;
      clear_logs();
      do_start(32'h103, 32'h2002, 16'd1);
      total++; if (dma_addr !== 32'h100) begin bad++; $display("FAIL align_src got=%h want=00000100", dma_addr); end
      wait_done(20, cyc, seen);
      total++; if (!seen || wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h2000 || wr_data_q[0] !== 32'hC0DE0100)
         begin bad++; $display("FAIL align_write got=%0d writes seen=%b want=1 at 2000 data c0de0100", wr_addr_q.size(), seen); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_stall();
      test_restart_ignored();
      test_reset_mid();
      test_wrap_align();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
